reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor register file for the RV32 core, with two read ports and two write ports (ALU writeback and load writeback). It adds optional write-to-read bypass and a per-register pending-write scoreboard for hazard detection. After every reset, a sequential init sweep clears the whole array before the block reports ready. It sits between decode (reads, issue marking) and the two writeback paths.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ra_a  input  ADDR_W  read index, port A (rs1)
ra_b  input  ADDR_W  read index, port B (rs2)
rd_a  output  DATA_W  read data, port A
rd_b  output  DATA_W  read data, port B
busy_a  output  1  register at ra_a has a pending write
busy_b  output  1  register at ra_b has a pending write
we0  input  1  write enable, ALU writeback
wa0  input  ADDR_W  write index, ALU writeback
wd0  input  DATA_W  write data, ALU writeback
we1  input  1  write enable, load writeback
wa1  input  ADDR_W  write index, load writeback
wd1  input  DATA_W  write data, load writeback
iss_en  input  1  instruction issued with a destination register
iss_rd  input  ADDR_W  destination register of the issued instruction
ready  output  1  init sweep complete; block accepting traffic

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - state=INIT, sweep counter=0, all pending bits=0, ready=0.
  - rd_a=rd_b=0, busy_a=busy_b=0.
- FSM states INIT and READY:
  - INIT: each cycle writes 0 to reg[cnt] and increments cnt. The cycle that writes reg[DEPTH-1] moves the FSM to READY.
  - ready rises at the DEPTH-th rising edge after reset deasserts (edge 32 at default parameters).
  - READY is held until the next reset.
- While ready=0:
  - we0, we1 and iss_en are ignored.
  - rd_* are forced to 0 and busy_* are forced to 0.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT and a full re-sweep. Array contents are not preserved.
- Register 0:
  - Reads always return 0 and busy is never set for it.
  - Writes and issue marks to index 0 are dropped.
- Reads are combinational, zero-latency:
  - Index 0 returns 0.
  - Otherwise, if BYPASS=1 and we1 && wa1==ra, the port returns wd1.
  - Otherwise, if BYPASS=1 and we0 && wa0==ra, the port returns wd0.
  - Otherwise the port returns the array value.
- Writes commit on the rising edge.
  - we0 and we1 to different indices both commit.
  - we0 and we1 to the same index: port 1 wins, both for the commit and for bypass.
- Scoreboard, updated on the rising edge in READY:
  - pending[iss_rd] is set if iss_en and iss_rd!=0.
  - pending[wa0] is cleared if we0; pending[wa1] is cleared if we1.
  - Set and clear of the same index in the same cycle: set wins (new producer).
- busy_x = pending[ra_x] && ra_x!=0 && !(BYPASS && a write to ra_x this cycle).
  - With BYPASS=0, busy stays high through the writeback cycle.
- No arithmetic beyond the sweep counter. The counter is ADDR_W+1 bits so it does not wrap before the terminal check.

Test Plan:
- Reset release with default parameters -> ready=0 for edges 1-31, ready=1 after edge 32. Every index then reads 0 and busy_a=busy_b=0.
- In READY: we0=1, wa0=5, wd0=0xDEADBEEF, ra_a=5.
  - BYPASS=1: rd_a=0xDEADBEEF in the same cycle.
  - BYPASS=0: rd_a shows the old value (0) that cycle and 0xDEADBEEF the next cycle.
- Same-cycle dual write: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> reg7 reads 0x22 afterwards. With BYPASS=1, rd_b=0x22 during that cycle with ra_b=7.
- Scoreboard, with ra_a=9 held throughout:
  - iss_en=1, iss_rd=9 -> busy_a=1 from the next cycle.
  - we1=1, wa1=9 at a later cycle -> busy_a=0 that cycle with BYPASS=1 and stays 0 afterwards.
  - iss and we to index 9 in the same cycle -> busy_a stays 1.
- Writes, issue and reads on index 0: we0=1, wa0=0, wd0=0xFFFFFFFF, iss_rd=0 -> ra_a=0 reads 0 and busy_a=0.
- reset pulsed low for 1 cycle mid-operation after writing reg3=0x1234:
  - ready drops asynchronously.
  - Writes are ignored during the new sweep.
  - ready returns after 32 edges and reg3 reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with init sweep, optional write-to-read
// bypass and a pending-write scoreboard for hazard detection.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              ready
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pend_set;
  logic [DEPTH-1:0]  w_pend_clr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_hit0_a;
  logic              w_hit1_a;
  logic              w_hit0_b;
  logic              w_hit1_b;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through this block leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        w_cnt_nxt = r_cnt + (ADDR_W + 1)'(1);
        if (r_cnt == LAST_IDX) w_state_nxt = S_READY;
      end
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_ready = (r_state == S_READY);
  assign ready   = w_ready;

  // NOTE: the array has no reset; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clock) begin
    if (!w_ready) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (we0 && (wa0 != '0)) r_mem[wa0] <= wd0;
      if (we1 && (wa1 != '0)) r_mem[wa1] <= wd1;
    end
  end

  // Entry 0 is never marked, so busy for x0 can never assert.
  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_pend_set[i] = iss_en && (iss_rd == ADDR_W'(i));
      w_pend_clr[i] = (we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)));
    end
  end

  // Set is OR-ed in after the clear so a new producer wins over writeback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (w_ready) begin
      r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
    end
  end

  assign w_hit0_a = BYPASS && we0 && (wa0 == ra_a);
  assign w_hit1_a = BYPASS && we1 && (wa1 == ra_a);
  assign w_hit0_b = BYPASS && we0 && (wa0 == ra_b);
  assign w_hit1_b = BYPASS && we1 && (wa1 == ra_b);

  // Load writeback (port 1) takes priority over ALU writeback when both hit.
  always_comb begin
    rd_a   = '0;
    rd_b   = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    if (w_ready) begin
      if (ra_a != '0) begin
        if (w_hit1_a)      rd_a = wd1;
        else if (w_hit0_a) rd_a = wd0;
        else               rd_a = r_mem[ra_a];
        busy_a = r_pending[ra_a] && !(w_hit0_a || w_hit1_a);
      end
      if (ra_b != '0) begin
        if (w_hit1_b)      rd_b = wd1;
        else if (w_hit0_b) rd_b = wd0;
        else               rd_b = r_mem[ra_b];
        busy_b = r_pending[ra_b] && !(w_hit0_b || w_hit1_b);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with bypass, one without, sharing inputs.
module tb_reg_file_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ra_a, ra_b, wa0, wa1, iss_rd;
  logic [31:0] wd0, wd1;
  logic        we0, we1, iss_en;

  logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        busy_a1, busy_b1, busy_a0, busy_b0, ready1, ready0;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] m_mem  [32];
  logic        m_pend [32];

  always #5 clock = ~clock;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clock(clock), .reset(reset), .ra_a(ra_a), .ra_b(ra_b),
    .rd_a(rd_a1), .rd_b(rd_b1), .busy_a(busy_a1), .busy_b(busy_b1),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_rd(iss_rd), .ready(ready1)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
    .clock(clock), .reset(reset), .ra_a(ra_a), .ra_b(ra_b),
    .rd_a(rd_a0), .rd_b(rd_b0), .busy_a(busy_a0), .busy_b(busy_b0),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_rd(iss_rd), .ready(ready0)
  );

  typedef struct {
    logic        we0;  logic [4:0] wa0;  logic [31:0] wd0;
    logic        we1;  logic [4:0] wa1;  logic [31:0] wd1;
    logic        iss_en; logic [4:0] iss_rd;
    logic [4:0]  ra_a; logic [4:0] ra_b;
    logic [31:0] e1_rd_a; logic [31:0] e1_rd_b; logic e1_busy_a; logic e1_busy_b;
    logic [31:0] e0_rd_a; logic [31:0] e0_rd_b; logic e0_busy_a; logic e0_busy_b;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
    iss_en = 1'b0; iss_rd = 5'd0;
  endtask

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    a = 5'($urandom);
    if ($urandom_range(0, 1) == 1) a[4:3] = 2'b00;
    return a;
  endfunction

  // Reference read: x0 is zero, bypass (port 1 first) only when enabled.
  function automatic logic [31:0] m_read(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic m_busy(input bit byp, input logic [4:0] ra);
    bit written;
    written = (we0 && wa0 == ra) || (we1 && wa1 == ra);
    return (ra != 5'd0) && m_pend[ra] && !(byp && written);
  endfunction

  initial begin
    // inputs: we0 wa0 wd0 | we1 wa1 wd1 | iss | ra_a ra_b | bypass exp | no-bypass exp
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                 32'hDEADBEEF, 32'h0, 1'b0, 1'b0,  32'h0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                 32'hDEADBEEF, 32'h0, 1'b0, 1'b0,  32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h22, 32'h22, 1'b0, 1'b0,  32'h0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h22, 32'hDEADBEEF, 1'b0, 1'b0,  32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7,
                 32'h0, 32'h22, 1'b0, 1'b0,  32'h0, 32'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7,
                 32'h0, 32'h22, 1'b1, 1'b0,  32'h0, 32'h22, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd7,
                 32'h99, 32'h22, 1'b0, 1'b0,  32'h0, 32'h22, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7,
                 32'h99, 32'h22, 1'b0, 1'b0,  32'h99, 32'h22, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7,
                 32'h99, 32'h22, 1'b0, 1'b0,  32'h99, 32'h22, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7,
                 32'hAA, 32'h22, 1'b0, 1'b0,  32'h99, 32'h22, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7,
                 32'hAA, 32'h22, 1'b1, 1'b0,  32'hAA, 32'h22, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9,
                 32'h0, 32'hAA, 1'b0, 1'b1,  32'h0, 32'hAA, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0,  32'h0, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h12, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h0, 32'h12, 1'b0, 1'b0,  32'h0, 32'hAA, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h1234, 32'h12, 1'b0, 1'b0,  32'h0, 32'h12, 1'b0, 1'b0};

    idle_inputs();
    ra_a = 5'd3; ra_b = 5'd4;

    // Held in reset: everything reads zero and ready is low.
    repeat (2) @(negedge clock);
    check("reset ready byp", 32'(ready1), 32'h0);
    check("reset ready nob", 32'(ready0), 32'h0);
    check("reset rd_a", rd_a1, 32'h0);
    check("reset busy_b", 32'(busy_b1), 32'h0);

    // Release: ready must rise exactly at the 32nd edge.
    reset = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock); #1;
      check($sformatf("sweep edge %0d ready byp", e), 32'(ready1), 32'(e == 32));
      check($sformatf("sweep edge %0d ready nob", e), 32'(ready0), 32'(e == 32));
    end

    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      ra_a = 5'(i); ra_b = 5'(31 - i);
      #1;
      check($sformatf("post-init rd_a[%0d]", i), rd_a1, 32'h0);
      check($sformatf("post-init rd_b[%0d]", 31 - i), rd_b0, 32'h0);
      check($sformatf("post-init busy_a[%0d]", i), 32'(busy_a1 | busy_a0), 32'h0);
    end

    // Directed table: bypass, dual write, scoreboard, register 0.
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_en = vecs[i].iss_en; iss_rd = vecs[i].iss_rd;
      ra_a = vecs[i].ra_a; ra_b = vecs[i].ra_b;
      #1;
      check($sformatf("v%0d byp rd_a", i),   rd_a1,          vecs[i].e1_rd_a);
      check($sformatf("v%0d byp rd_b", i),   rd_b1,          vecs[i].e1_rd_b);
      check($sformatf("v%0d byp busy_a", i), 32'(busy_a1),   32'(vecs[i].e1_busy_a));
      check($sformatf("v%0d byp busy_b", i), 32'(busy_b1),   32'(vecs[i].e1_busy_b));
      check($sformatf("v%0d nob rd_a", i),   rd_a0,          vecs[i].e0_rd_a);
      check($sformatf("v%0d nob rd_b", i),   rd_b0,          vecs[i].e0_rd_b);
      check($sformatf("v%0d nob busy_a", i), 32'(busy_a0),   32'(vecs[i].e0_busy_a));
      check($sformatf("v%0d nob busy_b", i), 32'(busy_b0),   32'(vecs[i].e0_busy_b));
    end

    // Mid-operation reset pulse after reg3 = 0x1234.
    @(negedge clock);
    idle_inputs();
    ra_a = 5'd3; ra_b = 5'd0;
    #1;
    check("pre-reset reg3 byp", rd_a1, 32'h1234);
    check("pre-reset reg3 nob", rd_a0, 32'h1234);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async ready drop byp", 32'(ready1), 32'h0);
    check("async ready drop nob", 32'(ready0), 32'h0);
    check("reset rd_a forced", rd_a1, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5555;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h6666;
    iss_en = 1'b1; iss_rd = 5'd3;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock); #1;
      check($sformatf("resweep edge %0d ready", e), 32'(ready1 & ready0), 32'(e == 32));
      if (e < 32) begin
        check($sformatf("resweep edge %0d rd_a", e), rd_a1, 32'h0);
        check($sformatf("resweep edge %0d busy_a", e), 32'(busy_a0), 32'h0);
      end
    end
    @(negedge clock);
    idle_inputs();
    ra_a = 5'd3; ra_b = 5'd4;
    #1;
    check("resweep reg3 byp", rd_a1, 32'h0);
    check("resweep reg3 nob", rd_a0, 32'h0);
    check("resweep reg4 byp", rd_b1, 32'h0);
    check("resweep busy_a byp", 32'(busy_a1), 32'h0);
    check("resweep busy_a nob", 32'(busy_a0), 32'h0);

    // Random traffic against the reference model; array is clean here.
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom;
      iss_en = ($urandom_range(0, 2) == 0); iss_rd = rnd_addr();
      ra_a = rnd_addr(); ra_b = rnd_addr();
      #1;
      check($sformatf("rnd%0d byp rd_a", c),   rd_a1,        m_read(1'b1, ra_a));
      check($sformatf("rnd%0d byp rd_b", c),   rd_b1,        m_read(1'b1, ra_b));
      check($sformatf("rnd%0d byp busy_a", c), 32'(busy_a1), 32'(m_busy(1'b1, ra_a)));
      check($sformatf("rnd%0d byp busy_b", c), 32'(busy_b1), 32'(m_busy(1'b1, ra_b)));
      check($sformatf("rnd%0d nob rd_a", c),   rd_a0,        m_read(1'b0, ra_a));
      check($sformatf("rnd%0d nob rd_b", c),   rd_b0,        m_read(1'b0, ra_b));
      check($sformatf("rnd%0d nob busy_a", c), 32'(busy_a0), 32'(m_busy(1'b0, ra_a)));
      check($sformatf("rnd%0d nob busy_b", c), 32'(busy_b0), 32'(m_busy(1'b0, ra_b)));
      @(posedge clock);
      if (we0) m_pend[wa0] = 1'b0;
      if (we1) m_pend[wa1] = 1'b0;
      if (iss_en && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
      if (we0 && wa0 != 5'd0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 5'd0) m_mem[wa1] = wd1;
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
